// File: rtl/lsu.sv
// Load/store stage: accepts one execute packet, performs an optional data-RAM
// access over a req/ack bus and presents a registered writeback packet.
module lsu #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           TIMEOUT     = 255,
    parameter int unsigned           ARGS_WIDTH  = 4,
    parameter logic [ARGS_WIDTH-1:0] INST_TYPE_L = ARGS_WIDTH'(32'd1)
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_e2l_valid,
    output logic                  o_lsu_ready,
    input  logic [ADDR_WIDTH-1:0] i_e2l_pc,
    input  logic [ARGS_WIDTH-1:0] i_e2l_ctr_inst_type,
    input  logic [ARGS_WIDTH-1:0] i_e2l_ctr_ram_byt,
    input  logic                  i_e2l_ctr_ram_wr_en,
    input  logic [DATA_WIDTH-1:0] i_e2l_res,
    input  logic [DATA_WIDTH-1:0] i_e2l_rs2_data,
    output logic                  o_lsu_ram_req,
    output logic                  o_lsu_ram_wr_en,
    output logic [ADDR_WIDTH-1:0] o_lsu_ram_addr,
    output logic [DATA_WIDTH-1:0] o_lsu_ram_wr_data,
    output logic [3:0]            o_lsu_ram_wr_mask,
    input  logic                  i_lsu_ram_ack,
    input  logic [DATA_WIDTH-1:0] i_lsu_ram_rd_data,
    input  logic                  i_l2w_ready,
    output logic                  o_lsu_valid,
    output logic [ADDR_WIDTH-1:0] o_lsu_pc,
    output logic [ARGS_WIDTH-1:0] o_lsu_ctr_inst_type,
    output logic [DATA_WIDTH-1:0] o_lsu_res,
    output logic                  o_lsu_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [ARGS_WIDTH-1:0] BYT_B  = ARGS_WIDTH'(32'd1);
    localparam logic [ARGS_WIDTH-1:0] BYT_H  = ARGS_WIDTH'(32'd2);
    localparam logic [ARGS_WIDTH-1:0] BYT_BU = ARGS_WIDTH'(32'd4);
    localparam logic [ARGS_WIDTH-1:0] BYT_HU = ARGS_WIDTH'(32'd5);

    typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, OUT = 2'd2} state_t;

    // Unknown size codes fall into the word rules in all helpers below.
    function automatic logic misaligned(input logic [ARGS_WIDTH-1:0] byt, input logic [1:0] off);
        case (byt)
            BYT_B, BYT_BU: misaligned = 1'b0;
            BYT_H, BYT_HU: misaligned = off[0];
            default:       misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [ARGS_WIDTH-1:0] byt, input logic [1:0] off);
        case (byt)
            BYT_B, BYT_BU: lane_mask = 4'b0001 << off;
            BYT_H, BYT_HU: lane_mask = 4'b0011 << off;
            default:       lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [ARGS_WIDTH-1:0] byt, input logic [31:0] rs2);
        case (byt)
            BYT_B, BYT_BU: lane_data = {4{rs2[7:0]}};
            BYT_H, BYT_HU: lane_data = {2{rs2[15:0]}};
            default:       lane_data = rs2;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [ARGS_WIDTH-1:0] byt,
                                                 input logic [1:0] off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (byt)
            BYT_B:   load_extract = {{24{sh[7]}}, sh[7:0]};
            BYT_BU:  load_extract = {24'd0, sh[7:0]};
            BYT_H:   load_extract = {{16{sh[15]}}, sh[15:0]};
            BYT_HU:  load_extract = {16'd0, sh[15:0]};
            default: load_extract = word;
        endcase
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    accept_s;
    logic                    is_load_s;
    logic                    is_mem_s;
    logic                    misalign_s;
    logic                    timeout_hit_s;
    logic [1:0]              off_s;
    logic [CW-1:0]           cnt_r;
    logic                    ready_r;
    logic                    valid_r;
    logic                    req_r;
    logic                    ram_wr_en_r;
    logic                    err_r;
    logic                    load_r;
    logic [1:0]              off_r;
    logic [ARGS_WIDTH-1:0]   byt_r;
    logic [ARGS_WIDTH-1:0]   type_r;
    logic [ADDR_WIDTH-1:0]   pc_r;
    logic [ADDR_WIDTH-1:0]   ram_addr_r;
    logic [DATA_WIDTH-1:0]   wr_data_r;
    logic [3:0]              wr_mask_r;
    logic [DATA_WIDTH-1:0]   out_res_r;

    assign accept_s      = i_e2l_valid && ready_r;
    assign off_s         = i_e2l_res[1:0];
    assign is_load_s     = (i_e2l_ctr_inst_type == INST_TYPE_L);
    assign is_mem_s      = is_load_s || i_e2l_ctr_ram_wr_en;
    assign misalign_s    = misaligned(i_e2l_ctr_ram_byt, off_s);
    assign timeout_hit_s = (cnt_r == CW'(TIMEOUT - 1));

    // FSM state register.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; an ack wins over a simultaneous timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (is_mem_s && !misalign_s) begin
                        state_next_s = MEM;
                    end else begin
                        state_next_s = OUT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            MEM: begin
                if (i_lsu_ram_ack || timeout_hit_s) begin
                    state_next_s = OUT;
                end else begin
                    state_next_s = MEM;
                end
            end
            OUT: begin
                if (i_l2w_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = OUT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Registered handshakes, RAM request payload and writeback payload.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            ready_r     <= 1'b1;
            valid_r     <= 1'b0;
            req_r       <= 1'b0;
            ram_wr_en_r <= 1'b0;
            err_r       <= 1'b0;
            load_r      <= 1'b0;
            off_r       <= 2'b00;
            byt_r       <= '0;
            type_r      <= '0;
            pc_r        <= '0;
            ram_addr_r  <= '0;
            wr_data_r   <= '0;
            wr_mask_r   <= 4'b0000;
            out_res_r   <= '0;
            cnt_r       <= '0;
        end else begin
            ready_r <= (state_next_s == IDLE);
            valid_r <= (state_next_s == OUT);
            req_r   <= (state_next_s == MEM);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        pc_r        <= i_e2l_pc;
                        type_r      <= i_e2l_ctr_inst_type;
                        byt_r       <= i_e2l_ctr_ram_byt;
                        off_r       <= off_s;
                        load_r      <= is_load_s;
                        ram_addr_r  <= {i_e2l_res[ADDR_WIDTH-1:2], 2'b00};
                        wr_data_r   <= lane_data(i_e2l_ctr_ram_byt, i_e2l_rs2_data);
                        wr_mask_r   <= lane_mask(i_e2l_ctr_ram_byt, off_s);
                        ram_wr_en_r <= i_e2l_ctr_ram_wr_en && !misalign_s;
                        out_res_r   <= i_e2l_res;
                        err_r       <= is_mem_s && misalign_s;
                        cnt_r       <= '0;
                    end
                end
                MEM: begin
                    if (i_lsu_ram_ack) begin
                        if (load_r && !ram_wr_en_r) begin
                            out_res_r <= load_extract(i_lsu_ram_rd_data, byt_r, off_r);
                        end
                        ram_wr_en_r <= 1'b0;
                        cnt_r       <= '0;
                    end else if (timeout_hit_s) begin
                        out_res_r   <= '0;
                        err_r       <= 1'b1;
                        ram_wr_en_r <= 1'b0;
                        cnt_r       <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(32'd1);
                    end
                end
                OUT: begin
                    if (i_l2w_ready) begin
                        err_r <= 1'b0;
                    end
                end
                default: begin
                    err_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_lsu_ready         = ready_r;
    assign o_lsu_valid         = valid_r;
    assign o_lsu_ram_req       = req_r;
    assign o_lsu_ram_wr_en     = ram_wr_en_r;
    assign o_lsu_ram_addr      = ram_addr_r;
    assign o_lsu_ram_wr_data   = wr_data_r;
    assign o_lsu_ram_wr_mask   = wr_mask_r;
    assign o_lsu_pc            = pc_r;
    assign o_lsu_ctr_inst_type = type_r;
    assign o_lsu_res           = out_res_r;
    assign o_lsu_err           = err_r;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table of single transactions plus
// hand-written backpressure and reset-during-access sequences.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        e2l_valid = 1'b0;
    logic        lsu_ready;
    logic [31:0] e2l_pc = 32'd0;
    logic [3:0]  e2l_type = 4'd0;
    logic [3:0]  e2l_byt = 4'd0;
    logic        e2l_wr = 1'b0;
    logic [31:0] e2l_res = 32'd0;
    logic [31:0] e2l_rs2 = 32'd0;
    logic        ram_req;
    logic        ram_wr_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_wr_data;
    logic [3:0]  ram_wr_mask;
    logic        ram_ack = 1'b0;
    logic [31:0] ram_rd_data = 32'd0;
    logic        l2w_ready = 1'b1;
    logic        lsu_valid;
    logic [31:0] lsu_pc;
    logic [3:0]  lsu_type;
    logic [31:0] lsu_res;
    logic        lsu_err;

    int tests = 0;
    int fails = 0;

    lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4), .ARGS_WIDTH(4), .INST_TYPE_L(4'd1)) dut (
        .i_sys_clk(clk), .i_sys_rst(rst),
        .i_e2l_valid(e2l_valid), .o_lsu_ready(lsu_ready),
        .i_e2l_pc(e2l_pc), .i_e2l_ctr_inst_type(e2l_type), .i_e2l_ctr_ram_byt(e2l_byt),
        .i_e2l_ctr_ram_wr_en(e2l_wr), .i_e2l_res(e2l_res), .i_e2l_rs2_data(e2l_rs2),
        .o_lsu_ram_req(ram_req), .o_lsu_ram_wr_en(ram_wr_en), .o_lsu_ram_addr(ram_addr),
        .o_lsu_ram_wr_data(ram_wr_data), .o_lsu_ram_wr_mask(ram_wr_mask),
        .i_lsu_ram_ack(ram_ack), .i_lsu_ram_rd_data(ram_rd_data),
        .i_l2w_ready(l2w_ready), .o_lsu_valid(lsu_valid), .o_lsu_pc(lsu_pc),
        .o_lsu_ctr_inst_type(lsu_type), .o_lsu_res(lsu_res), .o_lsu_err(lsu_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  typ;
        logic [3:0]  byt;
        logic        wr;
        logic [31:0] res;
        logic [31:0] rs2;
        logic [31:0] rd;
        int          ack_at;     // MEM cycle (1-based) on which ack is given; 0 = never
        int          exp_req;    // expected MEM cycles == cycles from accept to valid
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_mask;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        int n;
        int req_cycles;
        logic [31:0] pc;
        pc = 32'h0000_0100 + 32'(idx * 4);
        @(negedge clk);
        chk($sformatf("v%0d ready_idle", idx), 32'(lsu_ready), 32'd1);
        e2l_pc = pc; e2l_type = v.typ; e2l_byt = v.byt; e2l_wr = v.wr;
        e2l_res = v.res; e2l_rs2 = v.rs2; ram_rd_data = v.rd;
        l2w_ready = 1'b1; e2l_valid = 1'b1;
        @(negedge clk);
        e2l_valid = 1'b0;
        n = 0;
        req_cycles = 0;
        while (!lsu_valid && n < 50) begin
            if (ram_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    chk($sformatf("v%0d ready_mem", idx), 32'(lsu_ready), 32'd0);
                    chk($sformatf("v%0d addr", idx), ram_addr, v.exp_addr);
                    chk($sformatf("v%0d wr_en", idx), 32'(ram_wr_en), 32'(v.wr));
                    if (v.wr) begin
                        chk($sformatf("v%0d wdata", idx), ram_wr_data, v.exp_wdata);
                        chk($sformatf("v%0d mask", idx), 32'(ram_wr_mask), 32'(v.exp_mask));
                    end
                end
                ram_ack = (req_cycles == v.ack_at);
            end else begin
                ram_ack = 1'b0;
            end
            n++;
            @(negedge clk);
            ram_ack = 1'b0;
        end
        chk($sformatf("v%0d valid", idx), 32'(lsu_valid), 32'd1);
        chk($sformatf("v%0d req_cycles", idx), 32'(req_cycles), 32'(v.exp_req));
        chk($sformatf("v%0d latency", idx), 32'(n), 32'(v.exp_req));
        chk($sformatf("v%0d req_out", idx), 32'(ram_req), 32'd0);
        chk($sformatf("v%0d res", idx), lsu_res, v.exp_res);
        chk($sformatf("v%0d err", idx), 32'(lsu_err), 32'(v.exp_err));
        chk($sformatf("v%0d pc", idx), lsu_pc, pc);
        chk($sformatf("v%0d type", idx), 32'(lsu_type), 32'(v.typ));
        @(negedge clk);
        chk($sformatf("v%0d valid_drop", idx), 32'(lsu_valid), 32'd0);
        chk($sformatf("v%0d err_drop", idx), 32'(lsu_err), 32'd0);
    endtask

    initial begin
        //          typ    byt   wr    res            rs2            rd             ack req addr           wdata          mask     res            err
        vecs[0]  = '{4'd0, 4'd0, 1'b0, 32'h0000_0042, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         4'b0000, 32'h0000_0042, 1'b0}; // ADD
        vecs[1]  = '{4'd1, 4'd1, 1'b0, 32'h0000_1003, 32'h0,         32'h80FF_0000, 3, 3, 32'h0000_1000, 32'h0,         4'b0000, 32'hFFFF_FF80, 1'b0}; // LB
        vecs[2]  = '{4'd2, 4'd2, 1'b1, 32'h0000_2002, 32'h1234_ABCD, 32'h0,         1, 1, 32'h0000_2000, 32'hABCD_ABCD, 4'b1100, 32'h0000_2002, 1'b0}; // SH
        vecs[3]  = '{4'd1, 4'd3, 1'b0, 32'h0000_3001, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         4'b0000, 32'h0000_3001, 1'b1}; // LW misaligned
        vecs[4]  = '{4'd1, 4'd5, 1'b0, 32'h0000_4002, 32'h0,         32'h0,         0, 4, 32'h0000_4000, 32'h0,         4'b0000, 32'h0000_0000, 1'b1}; // LHU timeout
        vecs[5]  = '{4'd0, 4'd0, 1'b0, 32'h1234_5678, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         4'b0000, 32'h1234_5678, 1'b0}; // ADD after timeout
        vecs[6]  = '{4'd1, 4'd2, 1'b0, 32'h0000_5002, 32'h0,         32'h8001_7FFF, 1, 1, 32'h0000_5000, 32'h0,         4'b0000, 32'hFFFF_8001, 1'b0}; // LH
        vecs[7]  = '{4'd1, 4'd4, 1'b0, 32'h0000_6001, 32'h0,         32'h0000_9A00, 2, 2, 32'h0000_6000, 32'h0,         4'b0000, 32'h0000_009A, 1'b0}; // LBU
        vecs[8]  = '{4'd2, 4'd1, 1'b1, 32'h0000_7001, 32'hDEAD_BE5A, 32'h0,         1, 1, 32'h0000_7000, 32'h5A5A_5A5A, 4'b0010, 32'h0000_7001, 1'b0}; // SB
        vecs[9]  = '{4'd2, 4'd3, 1'b1, 32'h0000_8000, 32'hCAFE_F00D, 32'h0,         2, 2, 32'h0000_8000, 32'hCAFE_F00D, 4'b1111, 32'h0000_8000, 1'b0}; // SW
        vecs[10] = '{4'd1, 4'd3, 1'b0, 32'h0000_9004, 32'h0,         32'h1357_9BDF, 4, 4, 32'h0000_9004, 32'h0,         4'b0000, 32'h1357_9BDF, 1'b0}; // LW ack at timeout
        vecs[11] = '{4'd2, 4'd2, 1'b1, 32'h0000_A001, 32'h5555_AAAA, 32'h0,         0, 0, 32'h0,         32'h0,         4'b0000, 32'h0000_A001, 1'b1}; // SH misaligned
        vecs[12] = '{4'd1, 4'd7, 1'b0, 32'h0000_B002, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         4'b0000, 32'h0000_B002, 1'b1}; // unknown size as W, misaligned
        vecs[13] = '{4'd1, 4'd0, 1'b0, 32'h0000_C000, 32'h0,         32'h89AB_CDEF, 1, 1, 32'h0000_C000, 32'h0,         4'b0000, 32'h89AB_CDEF, 1'b0}; // unknown size as W

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst ready", 32'(lsu_ready), 32'd1);
        chk("rst valid", 32'(lsu_valid), 32'd0);
        chk("rst req", 32'(ram_req), 32'd0);
        chk("rst wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst mask", 32'(ram_wr_mask), 32'd0);
        chk("rst res", lsu_res, 32'd0);
        chk("rst err", 32'(lsu_err), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run(i, vecs[i]);
        end

        // Backpressure: payload must stay stable while the WBU stalls.
        @(negedge clk);
        e2l_pc = 32'h0000_0AA0; e2l_type = 4'd0; e2l_byt = 4'd0; e2l_wr = 1'b0;
        e2l_res = 32'h0000_0055; l2w_ready = 1'b0; e2l_valid = 1'b1;
        @(negedge clk);
        e2l_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d valid", k), 32'(lsu_valid), 32'd1);
            chk($sformatf("bp%0d res", k), lsu_res, 32'h0000_0055);
            chk($sformatf("bp%0d pc", k), lsu_pc, 32'h0000_0AA0);
            chk($sformatf("bp%0d ready", k), 32'(lsu_ready), 32'd0);
            @(negedge clk);
        end
        l2w_ready = 1'b1;
        @(negedge clk);
        chk("bp valid_drop", 32'(lsu_valid), 32'd0);
        chk("bp ready_back", 32'(lsu_ready), 32'd1);

        // Reset while a load is waiting for ack.
        e2l_pc = 32'h0000_0BB0; e2l_type = 4'd1; e2l_byt = 4'd3; e2l_wr = 1'b0;
        e2l_res = 32'h0000_D000; e2l_valid = 1'b1;
        @(negedge clk);
        e2l_valid = 1'b0;
        chk("mr req", 32'(ram_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mr req_drop", 32'(ram_req), 32'd0);
        chk("mr valid", 32'(lsu_valid), 32'd0);
        chk("mr ready", 32'(lsu_ready), 32'd1);
        rst = 1'b0;
        run(20, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store stage; the receiving end of the execute-to-LSU (e2l) valid/ready handshake.
- Accepts one execute result per transaction and performs any data-RAM access over a req/ack bus.
- Presents a registered writeback packet to the WBU over a second valid/ready handshake (l2w).
- Non-memory instructions pass through with one register stage.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; only 32 is supported.
- TIMEOUT, 255, maximum cycles spent waiting for i_lsu_ram_ack before the access is abandoned.

Ports:
- i_sys_clk  in  1  clock.
- i_sys_rst  in  1  synchronous, active-high reset.
- i_e2l_valid  in  1  execute packet valid.
- o_lsu_ready  out  1  LSU can accept a packet.
- i_e2l_pc  in  ADDR_WIDTH  instruction PC.
- i_e2l_ctr_inst_type  in  ARGS_WIDTH  instruction type; `INST_TYPE_L` marks a load.
- i_e2l_ctr_ram_byt  in  ARGS_WIDTH  access size: 1=B signed, 2=H signed, 3=W, 4=B unsigned, 5=H unsigned.
- i_e2l_ctr_ram_wr_en  in  1  store.
- i_e2l_res  in  DATA_WIDTH  ALU result (effective address for memory ops).
- i_e2l_rs2_data  in  DATA_WIDTH  store data.
- o_lsu_ram_req  out  1  RAM request, held until ack.
- o_lsu_ram_wr_en  out  1  request is a write.
- o_lsu_ram_addr  out  ADDR_WIDTH  word-aligned address ({res[31:2],2'b00}).
- o_lsu_ram_wr_data  out  DATA_WIDTH  lane-shifted store data.
- o_lsu_ram_wr_mask  out  4  byte strobes.
- i_lsu_ram_ack  in  1  request completed; read data valid in the same cycle.
- i_lsu_ram_rd_data  in  DATA_WIDTH  read word.
- i_l2w_ready  in  1  WBU can accept.
- o_lsu_valid  out  1  writeback packet valid.
- o_lsu_pc  out  ADDR_WIDTH  registered PC.
- o_lsu_ctr_inst_type  out  ARGS_WIDTH  registered instruction type.
- o_lsu_res  out  DATA_WIDTH  load data (loads) or ALU result (all others).
- o_lsu_err  out  1  misaligned access or timeout; valid alongside o_lsu_valid.

Behaviour:
- Reset: state IDLE. All outputs 0 except o_lsu_ready=1. Timeout counter cleared. Reset mid-access drops the request the same cycle and discards the packet.
- FSM states: IDLE, MEM, OUT.
- o_lsu_ready=1 only in IDLE. A packet is accepted when i_e2l_valid && o_lsu_ready; all inputs are captured into registers on that edge.
- IDLE, accept:
  - Non-memory (not load, wr_en=0): go to OUT, o_lsu_res=res. Latency 1 cycle.
  - Memory op, misaligned (H with addr[0]=1, W with addr[1:0]!=0): go to OUT with o_lsu_err=1 and o_lsu_res=res. No RAM access.
  - Memory op, aligned: go to MEM.
- MEM:
  - o_lsu_req=1; address, wr_en, data and mask are stable from registers.
  - On i_lsu_ram_ack: the load result is extracted and registered, then go to OUT. Drop req on the next edge.
  - The counter increments each MEM cycle without ack. On reaching TIMEOUT: drop req, set o_lsu_err=1, o_lsu_res=0, go to OUT.
  - An ack in the same cycle as the counter reaching TIMEOUT counts as success.
- OUT:
  - o_lsu_valid=1; payload held stable until i_l2w_ready.
  - Handshake cycle: return to IDLE; o_lsu_valid=0 and o_lsu_err=0 next cycle.
  - Throughput is at most 1 packet per 2 cycles; no bypass from OUT to accept.
- Store lanes, with off=addr[1:0]:
  - B: mask=4'b0001<<off, wr_data=rs2[7:0] replicated ×4.
  - H: mask=4'b0011<<off, wr_data=rs2[15:0] replicated ×2.
  - W: mask=4'b1111, wr_data=rs2.
- Load extract: lane selected by off, then sign-extend (codes 1, 2) or zero-extend (codes 4, 5). For stores, o_lsu_res=res.
- Unknown ram_byt code on a memory op is treated as W.

Test Plan:
- ADD, res=0x0000_0042, wr_en=0, i_l2w_ready=1 -> o_lsu_valid one cycle after accept, o_lsu_res=0x42, no req.
- LB signed, addr 0x1003, rd_data=0x80FF_0000, ack 3 cycles after req -> addr 0x1000, o_lsu_res=0xFFFF_FF80; ready=0 throughout MEM/OUT.
- SH, addr 0x2002, rs2=0x1234_ABCD -> mask 4'b1100, wr_data 0xABCD_ABCD, wr_en=1 held until ack; o_lsu_res=0x2002.
- LW at 0x3001 -> no req, o_lsu_valid with o_lsu_err=1 one cycle after accept.
- LHU with ack never asserted, TIMEOUT=4 -> req drops after 4 MEM cycles, o_lsu_err=1, o_lsu_res=0. Then a back-to-back ADD is accepted normally.
- i_l2w_ready held 0 for 5 cycles in OUT -> payload stable, o_lsu_ready=0. Separately, assert i_sys_rst during MEM -> req=0, valid=0, ready=1 the next cycle.
